// File: rtl/alu_result_collector_if.sv
// alu_result_collector_if
// Bundles the unit result/flag inputs, the consumer handshake and the
// FIFO status outputs of alu_result_collector.
//   master : producer/consumer side (drives results, flags, OUT_READY, CLR_ERR)
//   slave  : the collector (drives ALU_OUT, OUT_UNIT, OUT_VALID, status, errors)
interface alu_result_collector_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  logic [31:0]              Arith_OUT;
  logic                     Arith_Flag;
  logic [15:0]              Logic_OUT;
  logic                     Logic_Flag;
  logic [15:0]              CMP_OUT;
  logic                     CMP_Flag;
  logic [16:0]              Shift_OUT;
  logic                     Shift_Flag;
  logic                     OUT_READY;
  logic                     CLR_ERR;
  logic [DATA_WIDTH-1:0]    ALU_OUT;
  logic [1:0]               OUT_UNIT;
  logic                     OUT_VALID;
  logic [$clog2(DEPTH):0]   FIFO_COUNT;
  logic                     FULL;
  logic                     OVF_ERR;
  logic                     MULTI_ERR;

  modport master (
    output Arith_OUT, Arith_Flag, Logic_OUT, Logic_Flag, CMP_OUT, CMP_Flag,
           Shift_OUT, Shift_Flag, OUT_READY, CLR_ERR,
    input  ALU_OUT, OUT_UNIT, OUT_VALID, FIFO_COUNT, FULL, OVF_ERR, MULTI_ERR
  );

  modport slave (
    input  Arith_OUT, Arith_Flag, Logic_OUT, Logic_Flag, CMP_OUT, CMP_Flag,
           Shift_OUT, Shift_Flag, OUT_READY, CLR_ERR,
    output ALU_OUT, OUT_UNIT, OUT_VALID, FIFO_COUNT, FULL, OVF_ERR, MULTI_ERR
  );
endinterface

// File: rtl/alu_result_collector.sv
// alu_result_collector
// Collects results from four ALU units into a DEPTH-entry FIFO of
// {unit, data} pairs. One push per cycle, priority arith > logic > cmp > shift.
// Ports:
//   CLK : clock, rising edge
//   RST : asynchronous active-low reset
//   bus : alu_result_collector_if.slave (unit results/flags, OUT_READY,
//         CLR_ERR in; ALU_OUT, OUT_UNIT, OUT_VALID, FIFO_COUNT, FULL,
//         OVF_ERR, MULTI_ERR out)
module alu_result_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  alu_result_collector_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH+1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  ovf_err;
  logic                  multi_err;

  logic                  push_req;
  logic                  multi_req;
  logic [1:0]            push_unit;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  full;
  logic                  empty;
  logic                  pop;
  logic                  push_ok;
  logic                  ovf_evt;

  assign push_req  = bus.Arith_Flag | bus.Logic_Flag | bus.CMP_Flag | bus.Shift_Flag;
  assign multi_req = (bus.Arith_Flag & (bus.Logic_Flag | bus.CMP_Flag | bus.Shift_Flag)) |
                     (bus.Logic_Flag & (bus.CMP_Flag | bus.Shift_Flag)) |
                     (bus.CMP_Flag & bus.Shift_Flag);

  always_comb begin
    push_unit = 2'b00;
    push_data = '0;
    if (bus.Arith_Flag) begin
      push_unit = 2'b00;
      push_data = DATA_WIDTH'($signed(bus.Arith_OUT));
    end else if (bus.Logic_Flag) begin
      push_unit = 2'b01;
      push_data = DATA_WIDTH'(bus.Logic_OUT);
    end else if (bus.CMP_Flag) begin
      push_unit = 2'b10;
      push_data = DATA_WIDTH'(bus.CMP_OUT);
    end else if (bus.Shift_Flag) begin
      push_unit = 2'b11;
      push_data = DATA_WIDTH'(bus.Shift_OUT);
    end
  end

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop     = ~empty & bus.OUT_READY;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok = push_req & (~full | pop);
  assign ovf_evt = push_req & full & ~pop;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ovf_err   <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // New error events take precedence over a clear in the same cycle.
      ovf_err   <= ovf_evt   | (ovf_err   & ~bus.CLR_ERR);
      multi_err <= multi_req | (multi_err & ~bus.CLR_ERR);
    end
  end

  // Storage is not reset; the pointers and count alone define what is valid.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= {push_unit, push_data};
  end

  assign bus.ALU_OUT    = empty ? '0    : mem[rd_ptr][DATA_WIDTH-1:0];
  assign bus.OUT_UNIT   = empty ? 2'b00 : mem[rd_ptr][DATA_WIDTH+1:DATA_WIDTH];
  assign bus.OUT_VALID  = ~empty;
  assign bus.FIFO_COUNT = count;
  assign bus.FULL       = full;
  assign bus.OVF_ERR    = ovf_err;
  assign bus.MULTI_ERR  = multi_err;
endmodule

// File: tb/tb_alu_result_collector.sv
// tb_alu_result_collector
// Directed scenarios followed by a randomized run, all checked against a
// queue-based reference model of the collector.
module tb_alu_result_collector;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_result_collector_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  alu_result_collector #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Reference model: queue of {unit, data} plus sticky error bits.
  logic [DW+1:0] q[$];
  logic          m_ovf   = 1'b0;
  logic          m_multi = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf   = 1'b0;
    m_multi = 1'b0;
  endtask

  // Applies the rules to the inputs present at the coming edge.
  task automatic model_edge();
    int            nflags;
    logic          ovf_now;
    logic [1:0]    unit;
    logic [DW-1:0] data;
    bit            do_pop;
    int            size_before;
    nflags = int'(bus.Arith_Flag) + int'(bus.Logic_Flag) + int'(bus.CMP_Flag) + int'(bus.Shift_Flag);
    size_before = q.size();
    do_pop = (size_before > 0) && bus.OUT_READY;
    unit = 2'b00;
    data = '0;
    if (bus.Arith_Flag) begin
      unit = 2'd0;
      data = DW'(longint'($signed(bus.Arith_OUT)));
    end else if (bus.Logic_Flag) begin
      unit = 2'd1;
      data = DW'(longint'(bus.Logic_OUT));
    end else if (bus.CMP_Flag) begin
      unit = 2'd2;
      data = DW'(longint'(bus.CMP_OUT));
    end else if (bus.Shift_Flag) begin
      unit = 2'd3;
      data = DW'(longint'(bus.Shift_OUT));
    end
    ovf_now = (nflags > 0) && (size_before == DEPTH) && !do_pop;
    if (do_pop) void'(q.pop_front());
    if (nflags > 0 && !ovf_now) q.push_back({unit, data});
    m_ovf   = ovf_now      | (m_ovf   & ~bus.CLR_ERR);
    m_multi = (nflags > 1) | (m_multi & ~bus.CLR_ERR);
  endtask

  task automatic check_all(input string tag);
    logic [DW+1:0] head;
    head = (q.size() > 0) ? q[0] : '0;
    chk({tag, ".valid"}, 64'(bus.OUT_VALID),  64'(q.size() > 0));
    chk({tag, ".data"},  64'(bus.ALU_OUT),    64'(head[DW-1:0]));
    chk({tag, ".unit"},  64'(bus.OUT_UNIT),   64'(head[DW+1:DW]));
    chk({tag, ".count"}, 64'(bus.FIFO_COUNT), 64'(q.size()));
    chk({tag, ".full"},  64'(bus.FULL),       64'(q.size() == DEPTH));
    chk({tag, ".ovf"},   64'(bus.OVF_ERR),    64'(m_ovf));
    chk({tag, ".multi"}, 64'(bus.MULTI_ERR),  64'(m_multi));
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    bus.Arith_Flag = 1'b0;
    bus.Logic_Flag = 1'b0;
    bus.CMP_Flag   = 1'b0;
    bus.Shift_Flag = 1'b0;
    bus.CLR_ERR    = 1'b0;
  endtask

  initial begin
    bus.Arith_OUT = '0;
    bus.Logic_OUT = '0;
    bus.CMP_OUT   = '0;
    bus.Shift_OUT = '0;
    bus.OUT_READY = 1'b0;
    idle_inputs();
    model_reset();

    // Reset state, held across an edge.
    #12;
    check_all("reset");
    chk("reset.valid_c", 64'(bus.OUT_VALID), 64'(0));
    RST = 1'b1;

    // Sign extension, first push after reset release.
    bus.Arith_OUT  = 32'hFFFF_FFF6;
    bus.Arith_Flag = 1'b1;
    bus.OUT_READY  = 1'b1;
    cycle("sext0");
    chk("sext.data_c", 64'(bus.ALU_OUT),   64'h0000_0000_FFFF_FFF6);
    chk("sext.unit_c", 64'(bus.OUT_UNIT),  64'(0));
    chk("sext.vld_c",  64'(bus.OUT_VALID), 64'(1));
    bus.Arith_Flag = 1'b0;
    cycle("sext1");
    chk("sext.empty_c", 64'(bus.OUT_VALID), 64'(0));
    chk("sext.zero_c",  64'(bus.ALU_OUT),   64'(0));

    // Zero extension, flag held 3 cycles.
    bus.OUT_READY  = 1'b0;
    bus.Shift_OUT  = 17'h1FFFE;
    bus.Shift_Flag = 1'b1;
    for (int i = 0; i < 3; i++) cycle("zext");
    bus.Shift_Flag = 1'b0;
    chk("zext.count_c", 64'(bus.FIFO_COUNT), 64'(3));
    chk("zext.data_c",  64'(bus.ALU_OUT),    64'h0001_FFFE);
    chk("zext.unit_c",  64'(bus.OUT_UNIT),   64'(3));
    cycle("zext_hold");
    bus.OUT_READY = 1'b1;
    for (int i = 0; i < 3; i++) cycle("zext_drain");

    // Overflow: five pushes into four entries.
    bus.OUT_READY  = 1'b0;
    bus.Logic_Flag = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.Logic_OUT = 16'(i);
      cycle("ovf_fill");
    end
    bus.Logic_Flag = 1'b0;
    chk("ovf.full_c", 64'(bus.FULL),    64'(1));
    chk("ovf.err_c",  64'(bus.OVF_ERR), 64'(1));
    bus.OUT_READY = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("ovf.order_c", 64'(bus.ALU_OUT), 64'(i));
      cycle("ovf_pop");
    end
    bus.CLR_ERR = 1'b1;
    cycle("ovf_clr");
    bus.CLR_ERR = 1'b0;
    chk("ovf.cleared_c", 64'(bus.OVF_ERR), 64'(0));

    // Full with a simultaneous pop accepts the push.
    bus.OUT_READY  = 1'b0;
    bus.Logic_Flag = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.Logic_OUT = 16'(16'h10 + i);
      cycle("fp_fill");
    end
    bus.Logic_Flag = 1'b0;
    bus.OUT_READY  = 1'b1;
    bus.CMP_OUT    = 16'h00AA;
    bus.CMP_Flag   = 1'b1;
    cycle("fp_both");
    bus.CMP_Flag   = 1'b0;
    chk("fp.count_c", 64'(bus.FIFO_COUNT), 64'(4));
    chk("fp.ovf_c",   64'(bus.OVF_ERR),    64'(0));
    for (int i = 0; i < 3; i++) cycle("fp_drain");
    chk("fp.tail_c", 64'(bus.ALU_OUT),  64'h00AA);
    chk("fp.unit_c", 64'(bus.OUT_UNIT), 64'(2));
    cycle("fp_last");

    // Multiple flags: arith wins, MULTI_ERR set; clear; set beats clear.
    bus.OUT_READY  = 1'b0;
    bus.Arith_OUT  = 32'h0000_1234;
    bus.Logic_OUT  = 16'h5678;
    bus.Arith_Flag = 1'b1;
    bus.Logic_Flag = 1'b1;
    cycle("multi");
    idle_inputs();
    chk("multi.count_c", 64'(bus.FIFO_COUNT), 64'(1));
    chk("multi.unit_c",  64'(bus.OUT_UNIT),   64'(0));
    chk("multi.err_c",   64'(bus.MULTI_ERR),  64'(1));
    bus.CLR_ERR = 1'b1;
    cycle("multi_clr");
    chk("multi.clr_c", 64'(bus.MULTI_ERR), 64'(0));
    bus.CMP_Flag   = 1'b1;
    bus.Shift_Flag = 1'b1;
    cycle("multi_setwins");
    idle_inputs();
    chk("multi.setwins_c", 64'(bus.MULTI_ERR), 64'(1));

    // Asynchronous reset between edges with two entries stored.
    bus.OUT_READY = 1'b1;
    bus.CLR_ERR   = 1'b1;
    for (int i = 0; i < 3; i++) cycle("rst_prep");
    bus.CLR_ERR   = 1'b0;
    bus.OUT_READY = 1'b0;
    bus.CMP_Flag  = 1'b1;
    bus.CMP_OUT   = 16'h0001;
    cycle("rst_fill");
    bus.CMP_OUT   = 16'h0002;
    cycle("rst_fill");
    bus.CMP_Flag  = 1'b0;
    chk("rst.pre_count_c", 64'(bus.FIFO_COUNT), 64'(2));
    #2;
    RST = 1'b0;
    #1;
    model_reset();
    chk("rst.valid_c", 64'(bus.OUT_VALID),  64'(0));
    chk("rst.count_c", 64'(bus.FIFO_COUNT), 64'(0));
    chk("rst.data_c",  64'(bus.ALU_OUT),    64'(0));
    @(posedge CLK);
    #3;
    RST = 1'b1;
    check_all("rst_release");

    // Randomized run.
    for (int n = 0; n < 400; n++) begin
      bus.Arith_OUT  = $urandom;
      bus.Logic_OUT  = 16'($urandom);
      bus.CMP_OUT    = 16'($urandom);
      bus.Shift_OUT  = 17'($urandom);
      bus.Arith_Flag = ($urandom_range(0, 9) < 2);
      bus.Logic_Flag = ($urandom_range(0, 9) < 2);
      bus.CMP_Flag   = ($urandom_range(0, 9) < 2);
      bus.Shift_Flag = ($urandom_range(0, 9) < 2);
      bus.OUT_READY  = ($urandom_range(0, 9) < 4);
      bus.CLR_ERR    = ($urandom_range(0, 19) == 0);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
